// File: rtl/q_sys_msgdma_0_width_downsizer_if.sv
// q_sys_msgdma_0_width_downsizer_if: Avalon-ST wide input / narrow output bundle for the width downsizer
//   in_valid/in_ready/in_data             : IN_W-bit upstream word channel
//   out_valid/out_ready/out_data/out_last : OUT_W-bit downstream beat channel
//   slave modport = downsizer view, master modport = source/sink view
interface q_sys_msgdma_0_width_downsizer_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/q_sys_msgdma_0_width_downsizer.sv
// q_sys_msgdma_0_width_downsizer: splits IN_W-bit Avalon-ST words into IN_W/OUT_W OUT_W-bit beats
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave modport of q_sys_msgdma_0_width_downsizer_if (word in, beats out)
//   beat_cnt : 32-bit accepted-beat counter, present only with Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
module q_sys_msgdma_0_width_downsizer #(
  parameter int IN_W      = 128,
  parameter int OUT_W     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                              clk,
  input logic                              reset_n,
  q_sys_msgdma_0_width_downsizer_if.slave  bus
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
  ,
  output logic [31:0]                      beat_cnt
`endif
);
  localparam int R  = IN_W / OUT_W;
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  generate
    if ((IN_W % OUT_W) != 0 || R < 2) begin : g_bad_widths
      $error("IN_W must be a multiple of OUT_W with at least two lanes");
    end
  endgenerate
  logic [IN_W-1:0] hold_q, hold_d;
  logic            hold_v_q, hold_v_d;
  logic [LW-1:0]   lane_q, lane_d, sel;
  logic            last, in_rdy, in_acc, out_acc;
  assign last    = hold_v_q && (lane_q == LW'(R - 1));
  assign in_rdy  = ~hold_v_q | (bus.out_ready & last);
  assign in_acc  = bus.in_valid & in_rdy;
  assign out_acc = hold_v_q & bus.out_ready;
  assign sel     = LSB_FIRST ? lane_q : LW'(R - 1) - lane_q;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = hold_v_q;
  assign bus.out_last  = last;
  assign bus.out_data  = hold_q[sel*OUT_W +: OUT_W];
  // a new word loads even while the last beat of the old one leaves, so streaming has no bubble
  always_comb begin
    hold_d   = in_acc ? bus.in_data : hold_q;
    hold_v_d = in_acc | (hold_v_q & ~(out_acc & last));
    lane_d   = (in_acc | (out_acc & last)) ? '0 : out_acc ? lane_q + 1'b1 : lane_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      lane_q   <= '0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      lane_q   <= lane_d;
    end
  end
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= out_acc ? cnt_q + 32'd1 : cnt_q;
  end
  assign beat_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_q_sys_msgdma_0_width_downsizer.sv
// tb_q_sys_msgdma_0_width_downsizer: scoreboard bench driving LSB-first and MSB-first downsizers in lockstep
module tb_q_sys_msgdma_0_width_downsizer;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  int           total, bad, mode;
  logic [32:0]  qa[$], qb[$];
  logic [127:0] w2;
  q_sys_msgdma_0_width_downsizer_if #(.IN_W(128), .OUT_W(32)) ba ();
  q_sys_msgdma_0_width_downsizer_if #(.IN_W(128), .OUT_W(32)) bb ();
  assign ba.in_valid  = in_valid;
  assign ba.in_data   = in_data;
  assign ba.out_ready = out_ready;
  assign bb.in_valid  = in_valid;
  assign bb.in_data   = in_data;
  assign bb.out_ready = out_ready;
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif
  q_sys_msgdma_0_width_downsizer #(.IN_W(128), .OUT_W(32), .LSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ba.slave)
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
    , .beat_cnt(cnt_a)
`endif
  );
  q_sys_msgdma_0_width_downsizer #(.IN_W(128), .OUT_W(32), .LSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bb.slave)
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
    , .beat_cnt(cnt_b)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic scb(input string nm, input logic v, input logic l, input logic ir,
                     input logic [31:0] d, inout logic [32:0] q[$]);
    chk({nm, " out_valid"}, v, q.size() != 0);
    chk({nm, " in_ready"}, ir, q.size() == 0 || (out_ready && q[0][32]));
    if (v && q.size() != 0) begin
      chk({nm, " out_data"}, d, q[0][31:0]);
      chk({nm, " out_last"}, l, q[0][32]);
      if (out_ready) void'(q.pop_front());
    end
  endtask
  task automatic push(input logic [127:0] w);
    for (int l = 0; l < 4; l++) begin
      qa.push_back({l == 3, w[l*32 +: 32]});
      qb.push_back({l == 3, w[(3-l)*32 +: 32]});
    end
  endtask
  task automatic send(input logic [127:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = ba.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) push(w);
    else begin
      total++;
      bad++;
      $display("FAIL send timeout: got in_ready=0 want 1");
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL drain timeout: got %0d/%0d beats left want 0", qa.size(), qb.size());
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] mk(input int i);
    return {16'(i), 16'h3333, 16'(i), 16'h2222, 16'(i), 16'h1111, 16'(i), 16'h0000};
  endfunction
  initial begin
    int n;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    mode      = 0;
    total     = 0;
    bad       = 0;
    w2        = 128'h33333333_22222222_11111111_00000000;
    fork
      forever begin
        @(posedge clk);
        #1;
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      forever begin
        @(negedge clk);
        if (reset_n) begin
          scb("lsb", ba.out_valid, ba.out_last, ba.in_ready, ba.out_data, qa);
          scb("msb", bb.out_valid, bb.out_last, bb.in_ready, bb.out_data, qb);
        end
      end
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", ba.out_valid, 1'b0);
    chk("rst in_ready", ba.in_ready, 1'b1);
    chk("rst out_last", ba.out_last, 1'b0);
    chk("rst out_data", ba.out_data, 32'h0);
    chk("rst msb out_valid", bb.out_valid, 1'b0);
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
    chk("rst beat_cnt", cnt_a, 32'h0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(w2);
    drain();
    for (int i = 1; i <= 8; i++) send(mk(i));
    drain();
    mode = 1;
    for (int i = 100; i < 200; i++) send(mk(i));
    drain();
    mode = 0;
    @(posedge clk);
    #1;
    send(w2);
    n = 0;
    while (qa.size() > 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("pre-reset beats left", qa.size(), 2);
    #2;
    reset_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    chk("async rst out_valid", ba.out_valid, 1'b0);
    chk("async rst in_ready", ba.in_ready, 1'b1);
    chk("async rst out_data", ba.out_data, 32'h0);
    chk("async rst msb out_valid", bb.out_valid, 1'b0);
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
    chk("async rst beat_cnt", cnt_a, 32'h0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(w2);
    drain();
`ifdef Q_SYS_MSGDMA_0_DOWNSIZER_BEAT_CNT_EN
    for (int i = 300; i < 324; i++) send(mk(i));
    drain();
    chk("beat_cnt lsb", cnt_a, 32'd100);
    chk("beat_cnt msb", cnt_b, 32'd100);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
